data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the processor's data port. Accepts one load/store request at a time from the datapath (address = ALU result, write data = register-file read port 2). Serves it from an internal word-addressed array after a programmable number of wait states. Signals completion with a one-cycle response pulse, so a stalling core can hold its pipeline on `req_ready` low.

## Interface
Parameters:
- `DEPTH_LOG2`, 10 — array holds 2^DEPTH_LOG2 32-bit words.
- `WAIT_CYCLES`, 2 — wait states between acceptance and completion; legal range 0..15.

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  1  — request present.
- `req_write`  in  1  — 1 = store, 0 = load.
- `req_adr`  in  32  — byte address.
- `req_wdata`  in  32  — store data.
- `req_ready`  out  1  — responder idle; request accepted when `req_valid && req_ready`.
- `rsp_valid`  out  1  — one-cycle completion pulse.
- `rsp_rdata`  out  32  — load data; 0 for stores and errors.
- `rsp_err`  out  1  — request was misaligned or out of range; qualified by `rsp_valid`.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready`=1. On handshake, latch write, address and wdata. Go to WAIT if WAIT_CYCLES>0, else RESP. Load wait counter with WAIT_CYCLES-1.
  - WAIT: `req_ready`=0. Decrement the counter each cycle. When the counter is 0, go to RESP.
  - RESP: `req_ready`=0, `rsp_valid`=1 for exactly one cycle, then IDLE.
- Word index = latched `adr[DEPTH_LOG2+1:2]`.
- Error when `adr[1:0]`≠0 or any of `adr[31:DEPTH_LOG2+2]`≠0.
  - On error: no array write, `rsp_rdata`=0, `rsp_err`=1.
- Store commit: array written on the clock edge entering RESP, only if no error.
- Load: `rsp_rdata` registered on the edge entering RESP from the array at the word index.
- Request inputs are ignored outside IDLE; the requester must hold them only until the handshake.
- Array contents are not reset and are X until written; verification preloads via backdoor.
- Outputs are registered, with no combinational path from request inputs to any output.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0.
- Latency from handshake edge to `rsp_valid` high is WAIT_CYCLES+1 cycles.
  - WAIT_CYCLES=0 gives `rsp_valid` the cycle after acceptance.
- Throughput: one request per WAIT_CYCLES+2 cycles. `req_ready` returns high the cycle after the `rsp_valid` pulse.
- `rsp_rdata`/`rsp_err` hold their values until the next response is loaded. Only the `rsp_valid` cycle is meaningful.
- Load following store to the same word returns the new data, because the store commits before the next acceptance.
- Reset asserted mid-request (WAIT or RESP):
  - return to IDLE immediately;
  - a pending store that has not reached RESP is dropped and the array is unchanged;
  - no `rsp_valid` pulse is produced.
- `req_valid` held high continuously is accepted again on each IDLE cycle; there is no double acceptance within one transaction.

## Structure
- Package `data_mem_pkg`:
  - state enum (IDLE/WAIT/RESP);
  - `WORD_BYTES`=4;
  - `MAX_WAIT`=15;
  - counter width constant (4 bits).
- Sub-module `dmem_array`:
  - synchronous single-port RAM, parameterised by DEPTH_LOG2;
  - ports: clk, we, word index, wdata, registered rdata;
  - no reset on storage.
- The top level holds the FSM, wait counter, request latches and error decode.

## Test plan
- Reset, WAIT_CYCLES=2:
  - during reset: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0;
  - after release, store 0xDEADBEEF to 0x10: `rsp_valid` 3 cycles after the handshake, `rsp_err`=0, `rsp_rdata`=0.
- Load 0x10 after that store:
  - `rsp_rdata`=0xDEADBEEF, `rsp_err`=0;
  - `req_ready` low for exactly 3 cycles, then high again.
- Error cases:
  - misaligned load 0x12: `rsp_err`=1, `rsp_rdata`=0;
  - store to 0x0000_1000 with DEPTH_LOG2=10: `rsp_err`=1, and word 0 is unchanged on readback.
- WAIT_CYCLES=0 back-to-back with `req_valid` held high:
  - store 0x1 to 0x4, then load 0x4;
  - responses 1 cycle after each acceptance, acceptances 2 cycles apart;
  - load returns 0x1.
- Reset mid-request: assert `rst` low during WAIT of a store of 0x55 to 0x20 (word previously 0xAA):
  - no `rsp_valid` pulse;
  - a post-reset load of 0x20 returns 0xAA.
- Address wrap boundary: store and load at the last word 0xFFC (DEPTH_LOG2=10):
  - succeeds with `rsp_err`=0;
  - address 0x1000 flags an error.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_e    : responder FSM states
//   WORD_BYTES : bytes per array word
//   MAX_WAIT   : largest supported wait-state count
//   CNT_W      : wait-counter width
package data_mem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned MAX_WAIT   = 15;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM; storage is never reset.
//   clk_i   : clock
//   we_i    : write enable
//   idx_i   : word index
//   wdata_i : write data
//   rdata_o : registered read data (old contents on a same-cycle write)
module dmem_array #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Write port and registered read port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
    rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data port: one load/store at a time,
// served from an internal word array after WAIT_CYCLES wait states.
//   clk, rst (async, active-low)
//   req_valid/req_write/req_adr/req_wdata : request, accepted when req_ready
//   req_ready : responder idle
//   rsp_valid : one-cycle completion pulse
//   rsp_rdata : load data (0 for stores and errors)
//   rsp_err   : misaligned or out-of-range request
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned OFS = $clog2(WORD_BYTES);
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  if (WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("WAIT_CYCLES exceeds MAX_WAIT");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enter_resp;
  logic             write_q;
  logic [31:0]      adr_q, wdata_q;
  logic             req_ready_q, rsp_valid_q, err_q, rd_ok_q;
  logic [31:0]      hold_q;
  logic [31:0]      arr_rdata;
  logic [31:0]      rsp_rdata_c;

  logic        hs;
  logic        write_m, err_m;
  logic [31:0] adr_m, wdata_m;

  assign hs = req_valid && (state_q == IDLE);

  // With zero wait states the array is accessed on the acceptance edge itself,
  // so the live request is used in IDLE and the latched copy afterwards.
  assign write_m = (state_q == IDLE) ? req_write : write_q;
  assign adr_m   = (state_q == IDLE) ? req_adr   : adr_q;
  assign wdata_m = (state_q == IDLE) ? req_wdata : wdata_q;
  assign err_m   = (adr_m[OFS-1:0] != '0) || ((adr_m >> (DEPTH_LOG2 + OFS)) != '0);

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (clk),
    .we_i   (enter_resp && write_m && !err_m),
    .idx_i  (adr_m[DEPTH_LOG2+OFS-1:OFS]),
    .wdata_i(wdata_m),
    .rdata_o(arr_rdata)
  );

  // Next-state and wait-counter logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array read data is captured on the edge entering RESP and is valid only
  // during RESP; the hold register keeps it visible afterwards.
  assign rsp_rdata_c = (state_q == RESP) ? (rd_ok_q ? arr_rdata : '0) : hold_q;

  // State, request latches and registered response flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      adr_q       <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rd_ok_q     <= 1'b0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      if (hs) begin
        write_q <= req_write;
        adr_q   <= req_adr;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        err_q   <= err_m;
        rd_ok_q <= !write_m && !err_m;
      end
      if (state_q == RESP) begin
        hold_q <= rsp_rdata_c;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_c;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance A uses WAIT_CYCLES=2, instance B WAIT_CYCLES=0.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;

  logic        a_valid, a_write, a_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_adr, a_wdata, a_rsp_rdata;
  logic        b_valid, b_write, b_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_adr, b_wdata, b_rsp_rdata;

  int n_checks;
  int n_fail;

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_write(a_write), .req_adr(a_adr), .req_wdata(a_wdata),
    .req_ready(a_ready), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_write(b_write), .req_adr(b_adr), .req_wdata(b_wdata),
    .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request on instance A; reports latency (0 = no response), cycles with
  // req_ready low, and the ready/valid state one cycle after the response.
  task automatic req_a(input logic w, input logic [31:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int rlow, output logic rdy_after, output logic vld_after);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_ready) break;
    end
    a_valid = 1'b1; a_write = w; a_adr = adr; a_wdata = wd;
    @(posedge clk);
    #1 a_valid = 1'b0;
    lat = 0; rlow = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!a_ready) rlow++;
      if (a_rsp_valid) begin
        lat = i; rd = a_rsp_rdata; er = a_rsp_err;
        break;
      end
    end
    @(negedge clk);
    rdy_after = a_ready;
    vld_after = a_rsp_valid;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
    n_checks++;
    if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
    n_checks++;
    if (a_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", a_rsp_rdata); end
    n_checks++;
    if (a_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", a_rsp_err); end
    n_checks++;
    if (b_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_b got=%b exp=1", b_ready); end
    rst = 1'b1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er, ra, va; int lat, rlow;
    req_a(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, rlow, ra, va);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL store_latency got=%0d exp=3", lat); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL store_err got=%b exp=0", er); end
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL store_rdata got=%h exp=0", rd); end
    req_a(1'b0, 32'h10, 32'h0, rd, er, lat, rlow, ra, va);
    n_checks++;
    if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata got=%h exp=deadbeef", rd); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL load_err got=%b exp=0", er); end
    n_checks++;
    if (rlow !== 3) begin n_fail++; $display("FAIL load_ready_low got=%0d exp=3", rlow); end
    n_checks++;
    if (ra !== 1'b1) begin n_fail++; $display("FAIL load_ready_after got=%b exp=1", ra); end
    n_checks++;
    if (va !== 1'b0) begin n_fail++; $display("FAIL load_single_pulse got=%b exp=0", va); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er, ra, va; int lat, rlow;
    req_a(1'b1, 32'h0, 32'h12345678, rd, er, lat, rlow, ra, va);
    req_a(1'b0, 32'h12, 32'h0, rd, er, lat, rlow, ra, va);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL misaligned_err got=%b exp=1", er); end
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL misaligned_rdata got=%h exp=0", rd); end
    req_a(1'b1, 32'h1000, 32'hCAFEF00D, rd, er, lat, rlow, ra, va);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL range_store_err got=%b exp=1", er); end
    req_a(1'b0, 32'h0, 32'h0, rd, er, lat, rlow, ra, va);
    n_checks++;
    if (rd !== 32'h12345678) begin n_fail++; $display("FAIL word0_unchanged got=%h exp=12345678", rd); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL word0_err got=%b exp=0", er); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er, ra, va; int lat, rlow;
    req_a(1'b1, 32'hFFC, 32'hA5A55A5A, rd, er, lat, rlow, ra, va);
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL last_word_store_err got=%b exp=0", er); end
    req_a(1'b0, 32'hFFC, 32'h0, rd, er, lat, rlow, ra, va);
    n_checks++;
    if (rd !== 32'hA5A55A5A) begin n_fail++; $display("FAIL last_word_load got=%h exp=a5a55a5a", rd); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL last_word_load_err got=%b exp=0", er); end
    req_a(1'b0, 32'h1000, 32'h0, rd, er, lat, rlow, ra, va);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL past_end_err got=%b exp=1", er); end
    req_a(1'b0, 32'h0, 32'h0, rd, er, lat, rlow, ra, va);
    n_checks++;
    if (rd !== 32'h12345678) begin n_fail++; $display("FAIL no_wrap_word0 got=%h exp=12345678", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er, ra, va; int lat, rlow; int pulses;
    req_a(1'b1, 32'h20, 32'hAA, rd, er, lat, rlow, ra, va);
    @(negedge clk);
    a_valid = 1'b1; a_write = 1'b1; a_adr = 32'h20; a_wdata = 32'h55;
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    #1;
    n_checks++;
    if (a_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got=%b exp=1", a_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (a_rsp_valid) pulses++;
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_rsp_valid) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin n_fail++; $display("FAIL midreset_no_pulse got=%0d exp=0", pulses); end
    req_a(1'b0, 32'h20, 32'h0, rd, er, lat, rlow, ra, va);
    n_checks++;
    if (rd !== 32'hAA) begin n_fail++; $display("FAIL midreset_store_dropped got=%h exp=aa", rd); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int rsp[$];
    logic [31:0] last_rd;
    logic last_err;
    last_rd = '0; last_err = 1'b1;
    @(negedge clk);
    b_valid = 1'b1; b_write = 1'b1; b_adr = 32'h4; b_wdata = 32'h1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (b_rsp_valid) begin
        rsp.push_back(i); last_rd = b_rsp_rdata; last_err = b_rsp_err;
      end
      if (b_ready && b_valid) acc.push_back(i);
      if (acc.size() == 1 && i > acc[0] && b_write) begin
        b_write = 1'b0; b_wdata = 32'h0;
      end
      if (acc.size() == 2 && i > acc[1]) b_valid = 1'b0;
    end
    b_valid = 1'b0;
    n_checks++;
    if (acc.size() != 2 || acc[0] != 0 || acc[1] != 2) begin
      n_fail++; $display("FAIL b2b_accept_spacing got_count=%0d exp=2 accepts at cycles 0,2", acc.size());
    end
    n_checks++;
    if (rsp.size() != 2 || rsp[0] != 1 || rsp[1] != 3) begin
      n_fail++; $display("FAIL b2b_response_timing got_count=%0d exp=2 responses at cycles 1,3", rsp.size());
    end
    n_checks++;
    if (last_rd !== 32'h1) begin n_fail++; $display("FAIL b2b_load_rdata got=%h exp=1", last_rd); end
    n_checks++;
    if (last_err !== 1'b0) begin n_fail++; $display("FAIL b2b_load_err got=%b exp=0", last_err); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0;
    a_valid = 1'b0; a_write = 1'b0; a_adr = '0; a_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_adr = '0; b_wdata = '0;
    test_reset();
    test_store_load();
    test_errors();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
